uart_tx_fsm: RTL and testbench

//  Frame controller and line driver for the UART transmitter.
//  - Accepts a byte handshake and drives the serializer's shift enable.
//  - Consumes serializer outputs (ser_data, ser_done).
//  - Builds the frame start(0), data LSB-first, optional parity, stop(1) and drives TX_OUT.
//  - Sits directly downstream of the serializer; TX_OUT is the top-level line.

---
 rtl/uart_tx_fsm.sv | 125 ++++++++++++
 tb/tb_uart_tx_fsm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: frame controller and line driver for the UART transmitter.
// Builds start(0), LSB-first data from the serializer, optional parity and
// stop(1) on TX_OUT, and drives the serializer's shift enable.
// Optional feature macro: UART_TX_PARITY_EN (parity state and parity logic).
// With the macro undefined, PAR_EN/PAR_TYP are still ports but are ignored.
module uart_tx_fsm #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DATA_VALID,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  BUSY,
  output logic                  TX_OUT
);

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t state;
  state_t state_n;
  logic   busy_n;

`ifdef UART_TX_PARITY_EN
  logic par_bit;
  logic par_bit_n;
  logic par_en_q;
  logic par_en_n;
`else
  // Parity inputs have no function in this build; keep them tied off visibly.
  logic unused_parity_inputs;
  assign unused_parity_inputs = ^{PAR_EN, PAR_TYP, P_DATA};
`endif

  // State, busy flag and per-frame parity settings register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      BUSY     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      BUSY     <= busy_n;
`ifdef UART_TX_PARITY_EN
      par_bit  <= par_bit_n;
      par_en_q <= par_en_n;
`endif
    end
  end

  // Next-state logic; parity settings are captured only at the accept edge.
  always_comb begin
    state_n   = state;
`ifdef UART_TX_PARITY_EN
    par_bit_n = par_bit;
    par_en_n  = par_en_q;
`endif
    case (state)
      IDLE: begin
        if (DATA_VALID && !BUSY) begin
          state_n   = START;
`ifdef UART_TX_PARITY_EN
          par_bit_n = (^P_DATA) ^ PAR_TYP;
          par_en_n  = PAR_EN;
`endif
        end
      end
      START: state_n = DATA;
      DATA: begin
        if (ser_done) begin
`ifdef UART_TX_PARITY_EN
          state_n = par_en_q ? PARITY : STOP;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_n = STOP;
`endif
      STOP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Busy for every cycle the next state is part of a frame; clears with STOP->IDLE.
    busy_n = (state_n != IDLE);
  end

  // Line and shift-enable decode from the state register only (no DATA_VALID path).
  always_comb begin
    TX_OUT = 1'b1;
    ser_en = 1'b0;
    case (state)
      START: TX_OUT = 1'b0;
      DATA: begin
        TX_OUT = ser_data;
        ser_en = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: TX_OUT = par_bit;
`endif
      default: begin
        TX_OUT = 1'b1;
        ser_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: directed bench for uart_tx_fsm paired with a small serializer model.
module tb_uart_tx_fsm;

  localparam int unsigned DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_IMPL = 1'b1;
`else
  localparam bit PAR_IMPL = 1'b0;
`endif

  logic          CLK;
  logic          RST;
  logic          DATA_VALID;
  logic [DW-1:0] P_DATA;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          ser_done;
  logic          ser_data;
  logic          ser_en;
  logic          BUSY;
  logic          TX_OUT;

  int n_cmp;
  int n_bad;

  uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_VALID(DATA_VALID),
    .P_DATA    (P_DATA),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .ser_done  (ser_done),
    .ser_data  (ser_data),
    .ser_en    (ser_en),
    .BUSY      (BUSY),
    .TX_OUT    (TX_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Serializer model: loads on accept, shifts LSB-first while enabled.
  logic [DW-1:0] ser_q;
  logic [2:0]    ser_cnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      ser_q   <= '0;
      ser_cnt <= '0;
    end else if (DATA_VALID && !BUSY) begin
      ser_q   <= P_DATA;
      ser_cnt <= '0;
    end else if (ser_en) begin
      ser_q   <= ser_q >> 1;
      ser_cnt <= ser_cnt + 3'd1;
    end
  end
  assign ser_data = ser_q[0];
  assign ser_done = (ser_cnt == 3'd7);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, 32'(TX_OUT), 32'd1);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_ser_en"}, 32'(ser_en), 32'd0);
  endtask

  // Offer byte d, then check the whole frame; mid-frame inputs are scrambled.
  task automatic send(input string tag, input logic [7:0] d, input logic pen, input logic ptyp,
                      input logic exp_par, input logic hold_dv, input logic [7:0] mid);
    DATA_VALID = 1'b1;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    tick();
    DATA_VALID = hold_dv;
    P_DATA     = mid;
    PAR_EN     = ~pen;
    PAR_TYP    = ~ptyp;
    chk({tag, "_start"}, 32'(TX_OUT), 32'd0);
    chk({tag, "_busy_start"}, 32'(BUSY), 32'd1);
    chk({tag, "_en_start"}, 32'(ser_en), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("%s_bit%0d", tag, i), 32'(TX_OUT), 32'(d[i]));
      chk($sformatf("%s_en%0d", tag, i), 32'(ser_en), 32'd1);
      chk($sformatf("%s_busy%0d", tag, i), 32'(BUSY), 32'd1);
    end
    if (PAR_IMPL && pen) begin
      tick();
      chk({tag, "_parity"}, 32'(TX_OUT), 32'(exp_par));
      chk({tag, "_en_par"}, 32'(ser_en), 32'd0);
      chk({tag, "_busy_par"}, 32'(BUSY), 32'd1);
    end
    tick();
    chk({tag, "_stop"}, 32'(TX_OUT), 32'd1);
    chk({tag, "_busy_stop"}, 32'(BUSY), 32'd1);
    chk({tag, "_en_stop"}, 32'(ser_en), 32'd0);
    tick();
    chk({tag, "_after_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_after_tx"}, 32'(TX_OUT), 32'd1);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    RST        = 1'b1;
    DATA_VALID = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Reset for two cycles, then five idle cycles.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle("reset");
    end
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("idle");
    end

    // A5 even parity -> 0.
    send("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    // Odd parity: 01 -> 0, 03 -> 1; then parity disabled.
    send("01odd", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    send("03odd", 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    send("03nopar", 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // DATA_VALID held across two bytes; FF offered mid-frame goes out only after 55.
    send("b2b55", 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
    send("b2bff", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("post_b2b");
    end

    // Mid-frame DATA_VALID pulse that is dropped before the frame ends is not queued.
    send("pulse", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81);
    DATA_VALID = 1'b0;
    tick();
    chk_idle("no_queue");

    // Reset during the 4th data bit of A5 (bit3 = 0).
    DATA_VALID = 1'b1;
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    tick();
    DATA_VALID = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rst_bit3", 32'(TX_OUT), 32'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_idle("abort");
    tick();
    chk_idle("abort2");
    send("after_rst", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // 80 with parity requested: odd count -> parity 1 where implemented.
    send("x80", 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
